// File: rtl/sprite_pixel_pipe.sv
// Sprite pixel back end: drives the sprite ROM address, resolves palette colour and transparency,
// and muxes the sprite against the background with optional per-frame flashing. Three-cycle latency.
module sprite_pixel_pipe #(
    parameter int unsigned ROM_DEPTH    = 32'd76800,
    parameter logic [3:0]  KEY_INDEX    = 4'h0,
    parameter int unsigned FLASH_FRAMES = 32'd8
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        blank_n,
    input  logic        sprite_en,
    input  logic [19:0] Addr_in,
    input  logic        flash_en,
    input  logic [23:0] bg_rgb,
    input  logic        pal_we,
    input  logic [3:0]  pal_waddr,
    input  logic [23:0] pal_wdata,
    output logic [19:0] rom_addr,
    input  logic [3:0]  rom_q,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        pix_valid
);

    localparam logic [19:0] DEPTH_20 = 20'(ROM_DEPTH);
    localparam logic [7:0]  CNT_LAST = 8'(FLASH_FRAMES - 32'd1);

    typedef struct packed {
        logic        sprite;
        logic        blank;
        logic        inrange;
        logic        flash;
        logic [23:0] bg;
    } side_t;

    side_t       s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [19:0] rom_addr_q, rom_addr_d;
    logic [3:0]  idx_q, idx_d;
    logic [23:0] rgb_q, rgb_d;
    logic        pix_valid_q, pix_valid_d;
    logic [23:0] pal_q [16];
    logic [23:0] pal_d [16];
    logic [7:0]  frame_cnt_q, frame_cnt_d;
    logic        flash_phase_q, flash_phase_d;
    logic        origin_prev_q, origin_prev_d;
    logic        origin_s, frame_evt_s, transparent_s;

    // Pipeline stage next-state: S1 captures inputs, S2/S3 carry sidebands alongside the ROM read.
    always_comb begin
        s1_d         = '0;
        s1_d.sprite  = sprite_en;
        s1_d.blank   = blank_n;
        s1_d.inrange = (Addr_in < DEPTH_20);
        s1_d.flash   = flash_en;
        s1_d.bg      = bg_rgb;
        rom_addr_d   = Addr_in;
        s2_d         = s1_q;
        s3_d         = s2_q;
        idx_d        = rom_q;
    end

    // Palette write port; the S3 read below sees the pre-write contents on the same edge.
    always_comb begin
        pal_d = pal_q;
        if (pal_we) begin
            pal_d[pal_waddr] = pal_wdata;
        end else begin
            pal_d = pal_q;
        end
    end

    // Frame-start detector and flash half-period counter, held cleared while flashing is off.
    always_comb begin
        origin_s      = (DrawX == 10'd0) && (DrawY == 10'd0);
        frame_evt_s   = origin_s && !origin_prev_q;
        origin_prev_d = origin_s;
        frame_cnt_d   = frame_cnt_q;
        flash_phase_d = flash_phase_q;
        if (!flash_en) begin
            frame_cnt_d   = 8'd0;
            flash_phase_d = 1'b0;
        end else if (frame_evt_s) begin
            if (frame_cnt_q == CNT_LAST) begin
                frame_cnt_d   = 8'd0;
                flash_phase_d = !flash_phase_q;
            end else begin
                frame_cnt_d   = frame_cnt_q + 8'd1;
            end
        end else begin
            frame_cnt_d   = frame_cnt_q;
            flash_phase_d = flash_phase_q;
        end
    end

    // Final colour select: blanking forces black, transparency falls back to the background.
    always_comb begin
        transparent_s = !s3_q.sprite || !s3_q.inrange || (idx_q == KEY_INDEX)
                        || (s3_q.flash && flash_phase_q);
        pix_valid_d   = s3_q.blank;
        if (!s3_q.blank) begin
            rgb_d = 24'h0;
        end else if (transparent_s) begin
            rgb_d = s3_q.bg;
        end else begin
            rgb_d = pal_q[idx_q];
        end
    end

    // State registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_q          <= '0;
            s2_q          <= '0;
            s3_q          <= '0;
            rom_addr_q    <= 20'd0;
            idx_q         <= 4'd0;
            rgb_q         <= 24'h0;
            pix_valid_q   <= 1'b0;
            frame_cnt_q   <= 8'd0;
            flash_phase_q <= 1'b0;
            origin_prev_q <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                pal_q[i] <= 24'h0;
            end
        end else begin
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            s3_q          <= s3_d;
            rom_addr_q    <= rom_addr_d;
            idx_q         <= idx_d;
            rgb_q         <= rgb_d;
            pix_valid_q   <= pix_valid_d;
            frame_cnt_q   <= frame_cnt_d;
            flash_phase_q <= flash_phase_d;
            origin_prev_q <= origin_prev_d;
            pal_q         <= pal_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign VGA_R     = rgb_q[23:16];
    assign VGA_G     = rgb_q[15:8];
    assign VGA_B     = rgb_q[7:0];
    assign pix_valid = pix_valid_q;

endmodule

// File: tb/tb_sprite_pixel_pipe.sv
// Testbench for sprite_pixel_pipe: directed scenarios plus a randomized run checked against
// a frame/palette/ROM reference model.
module tb_sprite_pixel_pipe;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [9:0]  DrawX = 10'd5;
    logic [9:0]  DrawY = 10'd5;
    logic        blank_n = 1'b0;
    logic        sprite_en = 1'b0;
    logic [19:0] Addr_in = 20'd0;
    logic        flash_en = 1'b0;
    logic [23:0] bg_rgb = 24'h0;
    logic        pal_we = 1'b0;
    logic [3:0]  pal_waddr = 4'd0;
    logic [23:0] pal_wdata = 24'h0;
    logic [19:0] rom_addr;
    logic [3:0]  rom_q = 4'd0;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        pix_valid;
    logic [23:0] rgb_o;

    logic [23:0] pal_m [16];
    int          n_checks = 0;
    int          n_pass = 0;

    sprite_pixel_pipe dut (
        .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank_n(blank_n),
        .sprite_en(sprite_en), .Addr_in(Addr_in), .flash_en(flash_en), .bg_rgb(bg_rgb),
        .pal_we(pal_we), .pal_waddr(pal_waddr), .pal_wdata(pal_wdata), .rom_addr(rom_addr),
        .rom_q(rom_q), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .pix_valid(pix_valid)
    );

    assign rgb_o = {VGA_R, VGA_G, VGA_B};

    always #5 Clk = !Clk;

    function automatic logic [3:0] rom_fn(input logic [19:0] a);
        if (a == 20'd1000) return 4'd5;
        else if (a == 20'd2000) return 4'd0;
        else if (a >= 20'd76800) return 4'd7;
        else return a[3:0] ^ a[11:8] ^ a[19:16];
    endfunction

    // Synchronous sprite ROM model: data valid one cycle after the address.
    always @(posedge Clk) rom_q <= rom_fn(rom_addr);

    function automatic logic [23:0] exp_rgb(input logic sp, input logic [19:0] a,
                                            input logic blank, input logic [23:0] bg,
                                            input logic hidden);
        if (!blank) return 24'h0;
        if (!sp || a >= 20'd76800 || rom_fn(a) == 4'h0 || hidden) return bg;
        return pal_m[rom_fn(a)];
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_pix(input logic sp, input logic [19:0] a, input logic blank,
                           input logic [23:0] bg);
        sprite_en = sp; Addr_in = a; blank_n = blank; bg_rgb = bg;
    endtask

    task automatic pal_write(input logic [3:0] a, input logic [23:0] d);
        pal_we = 1'b1; pal_waddr = a; pal_wdata = d;
        tick();
        pal_m[a] = d;
        pal_we = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 16; i++) pal_m[i] = 24'h0;
        #12 Reset_n = 1'b1;
        tick();
        pal_write(4'd5, 24'h123456);
        set_pix(1'b1, 20'd1000, 1'b1, 24'h010203);
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if (rgb_o !== 24'h123456) $display("FAIL reset_pre_rgb: got %h expected %h", rgb_o, 24'h123456); else n_pass++;
        #2 Reset_n = 1'b0;
        #1;
        n_checks++; if (rgb_o !== 24'h0) $display("FAIL reset_async_rgb: got %h expected %h", rgb_o, 24'h0); else n_pass++;
        n_checks++; if (pix_valid !== 1'b0) $display("FAIL reset_async_valid: got %b expected 0", pix_valid); else n_pass++;
        n_checks++; if (rom_addr !== 20'd0) $display("FAIL reset_async_addr: got %0d expected 0", rom_addr); else n_pass++;
        for (int i = 0; i < 16; i++) pal_m[i] = 24'h0;
        tick();
        #2 Reset_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            n_checks++; if (pix_valid !== 1'b0) $display("FAIL reset_refill_valid: edge %0d got %b expected 0", i, pix_valid); else n_pass++;
        end
        tick();
        n_checks++; if (pix_valid !== 1'b1) $display("FAIL reset_first_valid: got %b expected 1", pix_valid); else n_pass++;
        n_checks++; if (rgb_o !== 24'h0) $display("FAIL reset_palette_cleared: got %h expected %h", rgb_o, 24'h0); else n_pass++;
    endtask

    task automatic test_latency();
        pal_write(4'd5, 24'h123456);
        set_pix(1'b0, 20'd0, 1'b0, 24'h0);
        for (int i = 0; i < 4; i++) tick();
        set_pix(1'b1, 20'd1000, 1'b1, 24'h777777);
        tick();
        n_checks++; if (rom_addr !== 20'd1000) $display("FAIL latency_rom_addr: got %0d expected 1000", rom_addr); else n_pass++;
        set_pix(1'b0, 20'd0, 1'b0, 24'h0);
        tick();
        tick();
        n_checks++; if (pix_valid !== 1'b0) $display("FAIL latency_early: got %b expected 0", pix_valid); else n_pass++;
        tick();
        n_checks++; if (rgb_o !== 24'h123456) $display("FAIL latency_rgb: got %h expected %h", rgb_o, 24'h123456); else n_pass++;
        n_checks++; if (pix_valid !== 1'b1) $display("FAIL latency_valid: got %b expected 1", pix_valid); else n_pass++;
        tick();
        n_checks++; if (pix_valid !== 1'b0) $display("FAIL latency_after: got %b expected 0", pix_valid); else n_pass++;
    endtask

    task automatic test_transparency();
        logic [19:0] addrs [4];
        logic        sps [4];
        logic [23:0] exp;
        addrs[0] = 20'd2000;  sps[0] = 1'b1;
        addrs[1] = 20'd76800; sps[1] = 1'b1;
        addrs[2] = 20'd1000;  sps[2] = 1'b0;
        addrs[3] = 20'd76799; sps[3] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_pix(sps[k], addrs[k], 1'b1, 24'hAABBCC);
            for (int i = 0; i < 4; i++) tick();
            exp = exp_rgb(sps[k], addrs[k], 1'b1, 24'hAABBCC, 1'b0);
            n_checks++; if (rgb_o !== exp) $display("FAIL transparency_%0d: addr %0d got %h expected %h", k, addrs[k], rgb_o, exp); else n_pass++;
        end
    endtask

    task automatic test_blanking();
        set_pix(1'b1, 20'd1000, 1'b0, 24'h445566);
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if (rgb_o !== 24'h0) $display("FAIL blank_rgb: got %h expected %h", rgb_o, 24'h0); else n_pass++;
        n_checks++; if (pix_valid !== 1'b0) $display("FAIL blank_valid: got %b expected 0", pix_valid); else n_pass++;
        blank_n = 1'b1; tick();
        blank_n = 1'b0; tick();
        blank_n = 1'b1; tick();
        tick();
        n_checks++; if (rgb_o !== pal_m[5] || pix_valid !== 1'b1) $display("FAIL blank_align_0: got %h/%b expected %h/1", rgb_o, pix_valid, pal_m[5]); else n_pass++;
        tick();
        n_checks++; if (rgb_o !== 24'h0 || pix_valid !== 1'b0) $display("FAIL blank_align_1: got %h/%b expected 0/0", rgb_o, pix_valid); else n_pass++;
        tick();
        n_checks++; if (rgb_o !== pal_m[5] || pix_valid !== 1'b1) $display("FAIL blank_align_2: got %h/%b expected %h/1", rgb_o, pix_valid, pal_m[5]); else n_pass++;
    endtask

    task automatic test_palette_hazard();
        pal_write(4'd5, 24'h123456);
        set_pix(1'b1, 20'd1000, 1'b1, 24'h0);
        tick(); tick(); tick();
        pal_we = 1'b1; pal_waddr = 4'd5; pal_wdata = 24'hFF0000;
        tick();
        n_checks++; if (rgb_o !== 24'h123456) $display("FAIL hazard_old: got %h expected %h", rgb_o, 24'h123456); else n_pass++;
        pal_we = 1'b0;
        pal_m[5] = 24'hFF0000;
        tick();
        n_checks++; if (rgb_o !== 24'hFF0000) $display("FAIL hazard_new: got %h expected %h", rgb_o, 24'hFF0000); else n_pass++;
    endtask

    task automatic test_flash();
        int          events;
        logic        hidden;
        logic [23:0] exp;
        set_pix(1'b1, 20'd1000, 1'b1, 24'h0F0F0F);
        DrawX = 10'd5; DrawY = 10'd5;
        flash_en = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        flash_en = 1'b1;
        events = 0;
        for (int f = 0; f < 27; f++) begin
            for (int i = 0; i < 4; i++) tick();
            hidden = ((events / 8) % 2) == 1;
            exp = exp_rgb(1'b1, 20'd1000, 1'b1, 24'h0F0F0F, hidden);
            n_checks++; if (rgb_o !== exp) $display("FAIL flash_frame_%0d: got %h expected %h", f, rgb_o, exp); else n_pass++;
            DrawX = 10'd0; DrawY = 10'd0;
            tick();
            if (f % 3 == 0) begin tick(); tick(); end
            DrawX = 10'd5; DrawY = 10'd5;
            events++;
        end
        for (int i = 0; i < 4; i++) tick();
        hidden = ((events / 8) % 2) == 1;
        exp = exp_rgb(1'b1, 20'd1000, 1'b1, 24'h0F0F0F, hidden);
        n_checks++; if (rgb_o !== exp) $display("FAIL flash_before_drop: got %h expected %h", rgb_o, exp); else n_pass++;
        flash_en = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if (rgb_o !== pal_m[5]) $display("FAIL flash_drop_visible: got %h expected %h", rgb_o, pal_m[5]); else n_pass++;
        flash_en = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            DrawX = 10'd0; DrawY = 10'd0; tick();
            DrawX = 10'd5; DrawY = 10'd5;
            for (int i = 0; i < 4; i++) tick();
            exp = (e < 8) ? pal_m[5] : 24'h0F0F0F;
            n_checks++; if (rgb_o !== exp) $display("FAIL flash_restart_%0d: got %h expected %h", e, rgb_o, exp); else n_pass++;
        end
        flash_en = 1'b0;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_random();
        logic        p_sp [300];
        logic        p_bl [300];
        logic [19:0] p_ad [300];
        logic [23:0] p_bg [300];
        logic [23:0] exp;
        logic        expv;
        flash_en = 1'b0;
        for (int j = 0; j < 300; j++) begin
            p_sp[j] = ($urandom_range(0, 3) != 0);
            p_bl[j] = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 5))
                0: p_ad[j] = 20'd2000;
                1: p_ad[j] = 20'($urandom_range(76800, 1048575));
                default: p_ad[j] = 20'($urandom_range(0, 76799));
            endcase
            p_bg[j] = 24'($urandom);
            set_pix(p_sp[j], p_ad[j], p_bl[j], p_bg[j]);
            DrawX = 10'($urandom); DrawY = 10'($urandom);
            pal_we = ($urandom_range(0, 3) == 0);
            pal_waddr = 4'($urandom);
            pal_wdata = 24'($urandom);
            exp = 24'h0; expv = 1'b0;
            if (j >= 3) begin
                exp = exp_rgb(p_sp[j-3], p_ad[j-3], p_bl[j-3], p_bg[j-3], 1'b0);
                expv = p_bl[j-3];
            end
            if (pal_we) pal_m[pal_waddr] = pal_wdata;
            tick();
            if (j >= 3) begin
                n_checks++; if (rgb_o !== exp || pix_valid !== expv) $display("FAIL random_%0d: got %h/%b expected %h/%b", j, rgb_o, pix_valid, exp, expv); else n_pass++;
            end
        end
        pal_we = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_transparency();
        test_blanking();
        test_palette_hazard();
        test_flash();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
